// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use stalls, taken-branch
// flushes, EX operand forwarding selects and saturating debug event counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ID_Valid,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             ID_RegWrite,
  input  logic             ID_MemRead,
  input  logic [4:0]       ID_WriteReg,
  input  logic             EX_BranchTaken,
  output logic             PC_En,
  output logic             IFID_En,
  output logic             IFID_Flush,
  output logic             IDEX_Bubble,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  // EX keeps source info for forwarding; MEM and WB only need producer info.
  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] dst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } ex_entry_t;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] dst;
  } mem_entry_t;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic [4:0] dst;
  } wb_entry_t;

  ex_entry_t  ex_q, ex_d;
  mem_entry_t mem_q, mem_d;
  wb_entry_t  wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic stall;
  logic flush;
  logic issue;

  // Register $0 is hardwired to zero, so it can never be a hazard source.
  function automatic logic reg_match(input logic v, input logic rw,
                                     input logic [4:0] dst, input logic [4:0] r);
    return v & rw & (dst != 5'd0) & (dst == r);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] r,
                                         input mem_entry_t m, input wb_entry_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses & reg_match(m.v, m.rw, m.dst, r) & !m.mr) begin
      sel = 2'b10;
    end else if (uses & reg_match(w.v, w.rw, w.dst, r)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    stall = ID_Valid & ex_q.mr &
            ((ID_UsesRs & reg_match(ex_q.v, ex_q.rw, ex_q.dst, ID_Rs)) |
             (ID_UsesRt & reg_match(ex_q.v, ex_q.rw, ex_q.dst, ID_Rt)));
    flush = EX_BranchTaken & ex_q.v;
    issue = ID_Valid & !stall & !flush;

    PC_En       = !(stall & !flush);
    IFID_En     = !(stall & !flush);
    IFID_Flush  = flush;
    IDEX_Bubble = stall | flush;
    FwdA        = fwd_sel(ex_q.uses_rs, ex_q.rs, mem_q, wb_q);
    FwdB        = fwd_sel(ex_q.uses_rt, ex_q.rt, mem_q, wb_q);
    StallCount  = stall_cnt_q;
    FlushCount  = flush_cnt_q;
  end

  // Stalled or squashed ID instructions enter EX as an all-zero bubble.
  always_comb begin
    ex_d = '0;
    if (issue) begin
      ex_d.v       = 1'b1;
      ex_d.rw      = ID_RegWrite;
      ex_d.mr      = ID_MemRead;
      ex_d.dst     = ID_WriteReg;
      ex_d.rs      = ID_Rs;
      ex_d.rt      = ID_Rt;
      ex_d.uses_rs = ID_UsesRs;
      ex_d.uses_rt = ID_UsesRt;
    end
    mem_d = '{v: ex_q.v, rw: ex_q.rw, mr: ex_q.mr, dst: ex_q.dst};
    wb_d  = '{v: mem_q.v, rw: mem_q.rw, dst: mem_q.dst};

    stall_cnt_d = stall_cnt_q;
    if (stall & !flush & (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush & (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule
